mips_debug_frame_serializer: RTL and testbench

//  Debug-side data source for the MicroBlaze debug link. Accepts a one-cycle request (6-bit select) from the

---
 rtl/mips_debug_frame_serializer.sv | 180 ++++++++++++++++++
 tb/tb_mips_debug_frame_serializer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_debug_frame_serializer.sv
// Debug-link data source: on a one-cycle request, streams a fixed-length burst of frames taken from a GPR,
// the PC, a pipeline latch group or data/instruction memory, flagging the last frame with o_eod.
module mips_debug_frame_serializer #(
  parameter int NB_FRAME      = 32,
  parameter int NB_BUFFER     = 96,
  parameter int NB_ADDR_DATA  = 16,
  parameter int NB_INSTR_ADDR = 9
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_request_valid,
  input  logic [5:0]               i_request_select,
  input  logic [NB_ADDR_DATA-1:0]  i_mem_addr,
  output logic [4:0]               o_reg_addr,
  input  logic [NB_FRAME-1:0]      i_reg_data,
  input  logic [NB_FRAME-1:0]      i_pc,
  input  logic [NB_BUFFER-1:0]     i_latch_fetch_d,
  input  logic [NB_BUFFER-1:0]     i_latch_fetch_c,
  input  logic [NB_BUFFER-1:0]     i_latch_deco_d,
  input  logic [NB_BUFFER-1:0]     i_latch_deco_c,
  input  logic [NB_BUFFER-1:0]     i_latch_exec_d,
  input  logic [NB_BUFFER-1:0]     i_latch_exec_c,
  input  logic [NB_BUFFER-1:0]     i_latch_mem_d,
  input  logic [NB_BUFFER-1:0]     i_latch_mem_c,
  output logic                     o_dmem_rd_en,
  output logic [NB_ADDR_DATA-1:0]  o_dmem_addr,
  input  logic [NB_FRAME-1:0]      i_dmem_data,
  output logic                     o_imem_rd_en,
  output logic [NB_INSTR_ADDR-1:0] o_imem_addr,
  input  logic [NB_FRAME-1:0]      i_imem_data,
  output logic [NB_FRAME-1:0]      o_frame,
  output logic                     o_frame_valid,
  output logic                     o_eod,
  output logic                     o_busy
);

  localparam int N_WORDS = NB_BUFFER / NB_FRAME;
  localparam int CNT_W   = $clog2(N_WORDS + 1);
  localparam logic [CNT_W-1:0]              CNT_ONE  = 1;
  localparam logic [CNT_W-1:0]              CNT_LAST = CNT_W'(N_WORDS - 1);
  localparam logic [NB_ADDR_DATA-1:0]       ADDR_ONE = 1;
  localparam logic [NB_BUFFER-NB_FRAME-1:0] PAD      = '0;

  typedef enum logic [1:0] {IDLE, SNAP, PRIME, SEND} state_t;
  typedef enum logic [1:0] {SRC_SNAP, SRC_DMEM, SRC_IMEM} src_t;

  state_t                  state_q, state_d;
  src_t                    src_q, src_d;
  logic [NB_BUFFER-1:0]    snap_q, snap_d;
  logic [NB_ADDR_DATA-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NB_FRAME-1:0]     frame_q, frame_d;
  logic                    valid_q, valid_d;
  logic                    eod_q, eod_d;
  logic                    busy_q, busy_d;
  logic                    rd_issue;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    snap_d   = snap_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    valid_d  = valid_q;
    eod_d    = eod_q;
    busy_d   = busy_q;
    rd_issue = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_request_valid) begin
          busy_d  = 1'b1;
          cnt_d   = '0;
          addr_d  = i_mem_addr;
          src_d   = SRC_SNAP;
          state_d = SNAP;
          if (!i_request_select[5]) begin
            snap_d = {i_reg_data, PAD};
          end else begin
            case (i_request_select)
              6'b100000: begin src_d = SRC_DMEM; state_d = PRIME; end
              6'b100001: begin src_d = SRC_IMEM; state_d = PRIME; end
              6'b100010: snap_d = {i_pc, PAD};
              6'b100100: snap_d = i_latch_fetch_d;
              6'b100101: snap_d = i_latch_fetch_c;
              6'b100110: snap_d = i_latch_deco_d;
              6'b100111: snap_d = i_latch_deco_c;
              6'b101000: snap_d = i_latch_exec_d;
              6'b101001: snap_d = i_latch_exec_c;
              6'b101010: snap_d = i_latch_mem_d;
              6'b101011: snap_d = i_latch_mem_c;
              // Undefined selects still produce a full burst (of zeros) so the link never stalls.
              default:   snap_d = '0;
            endcase
          end
        end
      end
      SNAP: begin
        frame_d = snap_q[NB_BUFFER-1 -: NB_FRAME];
        snap_d  = snap_q << NB_FRAME;
        valid_d = 1'b1;
        eod_d   = (N_WORDS == 1);
        state_d = SEND;
      end
      PRIME: begin
        rd_issue = 1'b1;
        addr_d   = addr_q + ADDR_ONE;
        frame_d  = '0;
        valid_d  = 1'b1;
        eod_d    = (N_WORDS == 1);
        state_d  = SEND;
      end
      SEND: begin
        if (cnt_q == CNT_LAST) begin
          frame_d = '0;
          valid_d = 1'b0;
          eod_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          eod_d = (cnt_d == CNT_LAST);
          if (src_q == SRC_SNAP) begin
            frame_d = snap_q[NB_BUFFER-1 -: NB_FRAME];
            snap_d  = snap_q << NB_FRAME;
          end else begin
            rd_issue = 1'b1;
            addr_d   = addr_q + ADDR_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      src_q   <= SRC_SNAP;
      snap_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      eod_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      snap_q  <= snap_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      eod_q   <= eod_d;
      busy_q  <= busy_d;
    end
  end

  // Memory words come straight from the memory's output register, which keeps the same latency as snapshots.
  always_comb begin
    o_frame = frame_q;
    if (valid_q && src_q == SRC_DMEM) begin
      o_frame = i_dmem_data;
    end else if (valid_q && src_q == SRC_IMEM) begin
      o_frame = i_imem_data;
    end
  end

  assign o_reg_addr    = (state_q == IDLE && i_request_valid && !i_request_select[5]) ?
                         i_request_select[4:0] : 5'd0;
  assign o_dmem_rd_en  = rd_issue && (src_q == SRC_DMEM);
  assign o_imem_rd_en  = rd_issue && (src_q == SRC_IMEM);
  assign o_dmem_addr   = addr_q;
  assign o_imem_addr   = addr_q[NB_INSTR_ADDR-1:0];
  assign o_frame_valid = valid_q;
  assign o_eod         = eod_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_mips_debug_frame_serializer.sv
// Self-checking bench for mips_debug_frame_serializer: expected frames are queued when a request is
// driven and popped by a monitor whenever the DUT presents a valid frame.
module tb_mips_debug_frame_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [5:0]  req_sel;
  logic [15:0] mem_addr;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [31:0] pc;
  logic [95:0] latch_val [8];
  logic        dmem_rd_en, imem_rd_en;
  logic [15:0] dmem_addr;
  logic [8:0]  imem_addr;
  logic [31:0] dmem_data, imem_data;
  logic [31:0] frame;
  logic        frame_valid, eod, busy;

  logic [31:0] gpr [32];
  logic [32:0] exp_q [$];
  logic [15:0] dmem_log [$];
  logic [32:0] sb_exp;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign reg_data = gpr[reg_addr];

  mips_debug_frame_serializer dut (
    .i_clock(clk), .i_reset(rst_n), .i_request_valid(req_valid), .i_request_select(req_sel),
    .i_mem_addr(mem_addr), .o_reg_addr(reg_addr), .i_reg_data(reg_data), .i_pc(pc),
    .i_latch_fetch_d(latch_val[0]), .i_latch_fetch_c(latch_val[1]),
    .i_latch_deco_d(latch_val[2]), .i_latch_deco_c(latch_val[3]),
    .i_latch_exec_d(latch_val[4]), .i_latch_exec_c(latch_val[5]),
    .i_latch_mem_d(latch_val[6]), .i_latch_mem_c(latch_val[7]),
    .o_dmem_rd_en(dmem_rd_en), .o_dmem_addr(dmem_addr), .i_dmem_data(dmem_data),
    .o_imem_rd_en(imem_rd_en), .o_imem_addr(imem_addr), .i_imem_data(imem_data),
    .o_frame(frame), .o_frame_valid(frame_valid), .o_eod(eod), .o_busy(busy)
  );

  function automatic logic [31:0] dmem_fn(input logic [15:0] a);
    return {16'hDA7A, a};
  endfunction

  function automatic logic [31:0] imem_fn(input logic [8:0] a);
    return {16'h1F1F, 7'd0, a};
  endfunction

  // Memories with one cycle of read latency
  always @(posedge clk) begin
    if (dmem_rd_en) dmem_data <= dmem_fn(dmem_addr);
    if (imem_rd_en) imem_data <= imem_fn(imem_addr);
  end

  // Scoreboard monitor: every valid frame must match the oldest queued expectation
  always @(negedge clk) begin
    if (dmem_rd_en) dmem_log.push_back(dmem_addr);
    if (frame_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected: got frame %h eod %b, required no frame", frame, eod);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({eod, frame} !== sb_exp) begin
          errors++;
          $display("[TB] FAIL sb_frame: got eod %b frame %h, required eod %b frame %h",
                   eod, frame, sb_exp[32], sb_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic scramble();
    pc = $urandom;
    for (int i = 0; i < 8; i++) latch_val[i] = {$urandom, $urandom, $urandom};
    for (int i = 0; i < 32; i++) gpr[i] = $urandom;
  endtask

  task automatic push_snapshot(input logic [95:0] v);
    exp_q.push_back({1'b0, v[95:64]});
    exp_q.push_back({1'b0, v[63:32]});
    exp_q.push_back({1'b1, v[31:0]});
  endtask

  // Drives one strobe at a falling edge and follows the burst; poke[c] re-raises the strobe in cycle c.
  task automatic drive_request(input logic [5:0] sel, input logic [15:0] addr, input logic [15:0] poke,
                               output logic [4:0] strobe_reg_addr, output int first_valid,
                               output int eod_cyc, output int n_valid, output int idle_cyc,
                               output int dirty);
    req_sel = sel;
    mem_addr = addr;
    req_valid = 1'b1;
    #1 strobe_reg_addr = reg_addr;
    first_valid = -1; eod_cyc = -1; n_valid = 0; idle_cyc = -1; dirty = 0;
    @(negedge clk);
    for (int c = 1; c <= 12; c++) begin
      if (frame_valid) begin
        n_valid++;
        if (first_valid < 0) first_valid = c;
      end else if (frame !== 32'd0 || eod !== 1'b0) begin
        dirty++;
      end
      if (eod) eod_cyc = c;
      if (!busy) begin
        idle_cyc = c;
        break;
      end
      if (c == 1) scramble();
      req_valid = poke[c];
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_sel = 6'd0;
    mem_addr = 16'd0;
    scramble();
    @(negedge clk);
    checks++;
    if ({frame_valid, eod, busy, dmem_rd_en, imem_rd_en} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b, required 00000", {frame_valid, eod, busy, dmem_rd_en, imem_rd_en});
    end
    checks++;
    if (frame !== 32'd0) begin errors++; $display("[TB] FAIL reset_frame: got %h, required 0", frame); end
    checks++;
    if (dmem_addr !== 16'd0 || imem_addr !== 9'd0) begin
      errors++;
      $display("[TB] FAIL reset_addr: got %h/%h, required 0/0", dmem_addr, imem_addr);
    end
    checks++;
    if (reg_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_reg_addr: got %0d, required 0", reg_addr); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_gpr();
    logic [4:0] ra;
    int fv, ec, nv, ic, dt;
    gpr[5] = 32'hDEADBEEF;
    push_snapshot({32'hDEADBEEF, 64'd0});
    drive_request(6'b000101, 16'd0, 16'd0, ra, fv, ec, nv, ic, dt);
    checks++;
    if (ra !== 5'd5) begin errors++; $display("[TB] FAIL gpr_reg_addr: got %0d, required 5", ra); end
    checks++;
    if (fv !== 2) begin errors++; $display("[TB] FAIL gpr_first_valid: got %0d, required 2", fv); end
    checks++;
    if (ec !== 4) begin errors++; $display("[TB] FAIL gpr_eod_cycle: got %0d, required 4", ec); end
    checks++;
    if (nv !== 3) begin errors++; $display("[TB] FAIL gpr_count: got %0d, required 3", nv); end
    checks++;
    if (ic !== 5) begin errors++; $display("[TB] FAIL gpr_busy_low: got %0d, required 5", ic); end
    checks++;
    if (dt !== 0) begin errors++; $display("[TB] FAIL gpr_idle_frame: got %0d nonzero idle cycles, required 0", dt); end
    push_snapshot({gpr[31], 64'd0});
    drive_request(6'b011111, 16'd0, 16'd0, ra, fv, ec, nv, ic, dt);
    checks++;
    if (ra !== 5'd31) begin errors++; $display("[TB] FAIL gpr31_reg_addr: got %0d, required 31", ra); end
    checks++;
    if (nv !== 3) begin errors++; $display("[TB] FAIL gpr31_count: got %0d, required 3", nv); end
  endtask

  task automatic test_latch();
    logic [4:0] ra;
    int fv, ec, nv, ic, dt;
    latch_val[4] = 96'h1111_1111_2222_2222_3333_3333;
    push_snapshot(96'h1111_1111_2222_2222_3333_3333);
    drive_request(6'b101000, 16'd0, 16'd0, ra, fv, ec, nv, ic, dt);
    checks++;
    if (ec !== 4 || nv !== 3) begin
      errors++;
      $display("[TB] FAIL exec_d_burst: got eod %0d count %0d, required eod 4 count 3", ec, nv);
    end
    for (int i = 0; i < 8; i++) begin
      push_snapshot(latch_val[i]);
      drive_request(6'(36 + i), 16'd0, 16'd0, ra, fv, ec, nv, ic, dt);
      checks++;
      if (fv !== 2 || nv !== 3) begin
        errors++;
        $display("[TB] FAIL latch%0d_burst: got first %0d count %0d, required first 2 count 3", i, fv, nv);
      end
    end
  endtask

  task automatic test_dmem_wrap();
    logic [4:0] ra;
    int fv, ec, nv, ic, dt;
    dmem_log.delete();
    exp_q.push_back({1'b0, dmem_fn(16'hFFFF)});
    exp_q.push_back({1'b0, dmem_fn(16'h0000)});
    exp_q.push_back({1'b1, dmem_fn(16'h0001)});
    drive_request(6'b100000, 16'hFFFF, 16'd0, ra, fv, ec, nv, ic, dt);
    checks++;
    if (fv !== 2 || ec !== 4) begin
      errors++;
      $display("[TB] FAIL dmem_timing: got first %0d eod %0d, required first 2 eod 4", fv, ec);
    end
    checks++;
    if (dmem_log.size() !== 3) begin
      errors++;
      $display("[TB] FAIL dmem_reads: got %0d reads, required 3", dmem_log.size());
    end else begin
      checks++;
      if (dmem_log[0] !== 16'hFFFF || dmem_log[1] !== 16'h0000 || dmem_log[2] !== 16'h0001) begin
        errors++;
        $display("[TB] FAIL dmem_rd_addr: got %h %h %h, required ffff 0000 0001",
                 dmem_log[0], dmem_log[1], dmem_log[2]);
      end
    end
  endtask

  task automatic test_imem_wrap();
    logic [4:0] ra;
    int fv, ec, nv, ic, dt;
    exp_q.push_back({1'b0, imem_fn(9'h1FE)});
    exp_q.push_back({1'b0, imem_fn(9'h1FF)});
    exp_q.push_back({1'b1, imem_fn(9'h000)});
    drive_request(6'b100001, 16'hF1FE, 16'd0, ra, fv, ec, nv, ic, dt);
    checks++;
    if (nv !== 3 || ec !== 4) begin
      errors++;
      $display("[TB] FAIL imem_burst: got count %0d eod %0d, required count 3 eod 4", nv, ec);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ra;
    int fv, ec, nv, ic, dt, extra;
    pc = 32'h0BAD_F00D;
    push_snapshot({32'h0BAD_F00D, 64'd0});
    drive_request(6'b100010, 16'd0, 16'b0000_0000_0001_1000, ra, fv, ec, nv, ic, dt);
    checks++;
    if (nv !== 3 || ec !== 4 || ic !== 5) begin
      errors++;
      $display("[TB] FAIL ignore_strobe: got count %0d eod %0d idle %0d, required 3 4 5", nv, ec, ic);
    end
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (frame_valid || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("[TB] FAIL ignore_strobe_extra: got %0d busy cycles, required 0", extra); end
    push_snapshot({gpr[7], 64'd0});
    drive_request(6'b000111, 16'd0, 16'd0, ra, fv, ec, nv, ic, dt);
    push_snapshot({gpr[8], 64'd0});
    drive_request(6'b001000, 16'd0, 16'd0, ra, fv, ec, nv, ic, dt);
    checks++;
    if (fv !== 2 || nv !== 3) begin
      errors++;
      $display("[TB] FAIL back_to_back: got first %0d count %0d, required first 2 count 3", fv, nv);
    end
  endtask

  task automatic test_undef_pc();
    logic [4:0] ra;
    int fv, ec, nv, ic, dt;
    push_snapshot(96'd0);
    drive_request(6'b111111, 16'd0, 16'd0, ra, fv, ec, nv, ic, dt);
    checks++;
    if (ec !== 4 || nv !== 3) begin
      errors++;
      $display("[TB] FAIL undef_3f: got eod %0d count %0d, required eod 4 count 3", ec, nv);
    end
    push_snapshot(96'd0);
    drive_request(6'b100011, 16'd0, 16'd0, ra, fv, ec, nv, ic, dt);
    checks++;
    if (nv !== 3) begin errors++; $display("[TB] FAIL undef_23: got count %0d, required 3", nv); end
    pc = 32'h0000_0040;
    push_snapshot({32'h0000_0040, 64'd0});
    drive_request(6'b100010, 16'd0, 16'd0, ra, fv, ec, nv, ic, dt);
    checks++;
    if (ec !== 4 || nv !== 3) begin
      errors++;
      $display("[TB] FAIL pc_burst: got eod %0d count %0d, required eod 4 count 3", ec, nv);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [4:0] ra;
    int fv, ec, nv, ic, dt;
    exp_q.push_back({1'b0, dmem_fn(16'h1234)});
    exp_q.push_back({1'b0, dmem_fn(16'h1235)});
    req_sel = 6'b100000;
    mem_addr = 16'h1234;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({frame_valid, eod, busy, dmem_rd_en} !== 4'b0 || frame !== 32'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got valid %b eod %b busy %b rd %b frame %h, required all 0",
               frame_valid, eod, busy, dmem_rd_en, frame);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL mid_reset_partial: got %0d unsent frames, required 0", exp_q.size());
      exp_q.delete();
    end
    push_snapshot({gpr[3], 64'd0});
    drive_request(6'b000011, 16'd0, 16'd0, ra, fv, ec, nv, ic, dt);
    checks++;
    if (fv !== 2 || ec !== 4 || nv !== 3) begin
      errors++;
      $display("[TB] FAIL after_reset_burst: got first %0d eod %0d count %0d, required 2 4 3", fv, ec, nv);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_gpr();
    test_latch();
    test_dmem_wrap();
    test_imem_wrap();
    test_back_to_back();
    test_undef_pc();
    test_reset_mid_burst();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d frames never produced, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
